axi_10g_ethernet_0_tcp_tx_arbiter: RTL and testbench
====================================================

Name: axi_10g_ethernet_0_tcp_tx_arbiter

Overview:
Merges the TCP generator's two AXI4-Stream egress paths into the single 64-bit MAC TX stream: link-control frames (SYN/FIN/ACK) and user data frames. Arbitration is frame-granular, and no frame is ever interleaved with another. Link frames have priority, and a streak limit prevents them from starving user data. A per-frame watchdog aborts a stalled frame toward the MAC using tuser, then drains the offending source.

Parameters:
LINK_BURST_MAX, 4, max consecutive link grants while user_req is pending (1..255).
TIMEOUT_CYCLES, 1024, source-stall cycles before abort (>=2).
CNT_WIDTH, 32, width of the statistics counters.

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
link_req  in  1  link frame pending (tcp_link_en); held until first beat accepted
link_tdata  in  64  link stream data
link_tkeep  in  8  link byte enables
link_tvalid  in  1  link valid
link_tlast  in  1  link last beat
link_tready  out  1  link ready
user_req  in  1  user frame pending (tcp_user_en); same hold rule
user_tdata  in  64  user stream data
user_tkeep  in  8  user byte enables
user_tvalid  in  1  user valid
user_tlast  in  1  user last beat
user_tready  out  1  user ready
m_tdata  out  64  to MAC TX
m_tkeep  out  8  to MAC TX
m_tvalid  out  1  to MAC TX
m_tlast  out  1  to MAC TX
m_tuser  out  1  frame abort/underrun marker to MAC
m_tready  in  1  from MAC TX
link_sent  out  1  1-cycle pulse: link frame's tlast accepted
user_sent  out  1  1-cycle pulse: user frame's tlast accepted
abort_pulse  out  1  1-cycle pulse on entry to ABORT
busy  out  1  state != IDLE
link_frame_cnt  out  CNT_WIDTH  completed link frames, wraps
user_frame_cnt  out  CNT_WIDTH  completed user frames, wraps
abort_cnt  out  CNT_WIDTH  aborts, wraps

Behaviour:
- Reset (asynchronous, active-high, areset): state IDLE; all outputs 0; counters, streak and watchdog cleared. A frame in flight is truncated without tlast; the MAC is reset alongside.
- States: IDLE, LINK, USER, ABORT, FLUSH. State, streak and watchdog are registered. The data path is a combinational mux selected by state, so there is zero latency through the block.
- IDLE decision:
  - link_req only -> LINK.
  - user_req only -> USER.
  - Both requests -> USER if streak >= LINK_BURST_MAX, else LINK.
  - Neither -> stay in IDLE.
  - Both readies are 0 and m_tvalid is 0 in IDLE.
- Streak register:
  - +1 (saturating at 255) on a LINK grant made while user_req=1.
  - Cleared on any USER grant, and on a LINK grant made while user_req=0.
- LINK/USER:
  - m_* = granted source's signals; m_tuser=0.
  - granted tready = m_tready; the other tready = 0.
  - Accepted tlast beat -> IDLE, with the matching *_sent pulse and counter +1 in the same edge.
  - There is a mandatory one-cycle IDLE bubble between frames.
- Watchdog:
  - Counts cycles in LINK/USER where the granted tvalid=0.
  - Clears on any accepted beat.
  - Holds its value while tvalid=1 and m_tready=0, because MAC backpressure is never a fault.
  - Reaching TIMEOUT_CYCLES -> ABORT.
- ABORT:
  - Drives m_tvalid=1, m_tlast=1, m_tuser=1, m_tkeep=8'h01, m_tdata=0; both readies are 0.
  - Holds until m_tready=1, then goes to FLUSH.
  - abort_pulse and abort_cnt+1 occur on entry.
  - If the abort happens before the first beat of the frame, the MAC still receives this single aborted beat.
- FLUSH:
  - The aborted source's tready=1 and its beats are discarded; m_tvalid=0.
  - Exits to IDLE on an accepted tlast, or when the watchdog (restarted on entry) expires again.
  - No *_sent pulse and no frame count are produced.
- A request deasserted while its grant registers is a source protocol error. The watchdog recovers from it.
- Counters wrap modulo 2^CNT_WIDTH, and so does the statistics export.

Decomposition:
- Shared package axi_10g_ethernet_0_tcp_pkg holds:
  - the state enum (IDLE/LINK/USER/ABORT/FLUSH);
  - the constants ABORT_TKEEP=8'h01 and AXIS_DATA_W=64.
- One sub-module, axi_10g_ethernet_0_tcp_tx_watchdog, holds the stall counter: inputs are enable, restart and stall; output is expire.
- The mux and the FSM stay in the top module.

Test Plan:
- Single user frame, 5 beats, m_tready=1, last tkeep=8'h0F -> 5 beats on m_* unchanged; user_sent pulses on the 5th accept; user_frame_cnt=1; busy low one cycle later.
- link_req and user_req both held with continuous 2-beat frames, LINK_BURST_MAX=4 -> grant order L,L,L,L,U,L,L,L,L,U; one IDLE cycle between frames.
- Link frame mid-transfer with m_tready=0 for 2000 cycles, TIMEOUT_CYCLES=1024 -> no abort; the frame completes once m_tready=1.
- User source drops tvalid after beat 2 for 1024 cycles -> ABORT beat m_tuser=1, m_tlast=1, m_tkeep=8'h01; abort_cnt=1; the later 3 beats are absorbed in FLUSH with m_tvalid=0; then IDLE; user_frame_cnt unchanged.
- areset asserted mid-frame on beat 3 -> all outputs 0 asynchronously; after release, a new link frame is granted from IDLE normally.
- Counters with CNT_WIDTH=4 after 17 link frames -> link_frame_cnt=1.

Source files
------------

// File: rtl/axi_10g_ethernet_0_tcp_pkg.sv
// Shared definitions for the TCP TX egress arbiter.
//   arb_state_t  : arbiter FSM states
//   AXIS_DATA_W  : MAC-side AXI4-Stream data width
//   ABORT_TKEEP  : byte enables driven on the single aborted beat
package axi_10g_ethernet_0_tcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LINK,
        ST_USER,
        ST_ABORT,
        ST_FLUSH
    } arb_state_t;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam logic [7:0]  ABORT_TKEEP = 8'h01;

endpackage

// File: rtl/axi_10g_ethernet_0_tcp_tx_watchdog.sv
// Per-frame stall watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   enable   : a frame (or flush) is in progress
//   restart  : clear the count (beat accepted or not enabled)
//   stall    : source presented no valid beat this cycle
//   expire   : combinational; high on the TIMEOUT_CYCLES-th stalled cycle
// Cycles with neither stall nor restart leave the count unchanged, so
// downstream backpressure never advances the timeout.
module axi_10g_ethernet_0_tcp_tx_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    input  logic stall,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable && stall) begin
            count <= count + W'(1);
        end
    end

    assign expire = enable && stall && !restart && (count == LAST);

endmodule

// File: rtl/axi_10g_ethernet_0_tcp_tx_arbiter.sv
// Frame-granular arbiter merging the TCP link-control and user-data
// AXI4-Stream paths onto the 64-bit MAC TX stream.
//   aclk, areset          : clock, asynchronous active-high reset
//   link_* / user_*       : source streams plus frame-pending requests
//   m_*                   : merged stream toward the MAC (m_tuser = abort)
//   link_sent, user_sent  : pulse after a frame's tlast is accepted
//   abort_pulse           : pulse on entry to the abort state
//   busy                  : FSM not idle
//   *_cnt                 : wrapping frame / abort statistics
// Link frames win arbitration until LINK_BURST_MAX consecutive link grants
// have been made with user data waiting. The data path is a pure mux.
module axi_10g_ethernet_0_tcp_tx_arbiter
    import axi_10g_ethernet_0_tcp_pkg::*;
#(
    parameter int unsigned LINK_BURST_MAX = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   link_req,
    input  logic [AXIS_DATA_W-1:0] link_tdata,
    input  logic [7:0]             link_tkeep,
    input  logic                   link_tvalid,
    input  logic                   link_tlast,
    output logic                   link_tready,
    input  logic                   user_req,
    input  logic [AXIS_DATA_W-1:0] user_tdata,
    input  logic [7:0]             user_tkeep,
    input  logic                   user_tvalid,
    input  logic                   user_tlast,
    output logic                   user_tready,
    output logic [AXIS_DATA_W-1:0] m_tdata,
    output logic [7:0]             m_tkeep,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    output logic                   m_tuser,
    input  logic                   m_tready,
    output logic                   link_sent,
    output logic                   user_sent,
    output logic                   abort_pulse,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   link_frame_cnt,
    output logic [CNT_WIDTH-1:0]   user_frame_cnt,
    output logic [CNT_WIDTH-1:0]   abort_cnt
);

    localparam logic [7:0] BURST_MAX = 8'(LINK_BURST_MAX);

    arb_state_t state, state_nxt;
    logic [7:0] streak;
    logic       flush_user;   // source being drained in FLUSH is user
    logic       beat_acc;
    logic       wd_enable, wd_stall, wd_restart, wd_expire;

    assign busy       = (state != ST_IDLE);
    assign wd_enable  = (state == ST_LINK) || (state == ST_USER) || (state == ST_FLUSH);
    assign wd_restart = !wd_enable || beat_acc;

    axi_10g_ethernet_0_tcp_tx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (aclk),
        .rst    (areset),
        .enable (wd_enable),
        .restart(wd_restart),
        .stall  (wd_stall),
        .expire (wd_expire)
    );

    always_comb begin
        state_nxt   = state;
        m_tdata     = '0;
        m_tkeep     = '0;
        m_tvalid    = 1'b0;
        m_tlast     = 1'b0;
        m_tuser     = 1'b0;
        link_tready = 1'b0;
        user_tready = 1'b0;
        beat_acc    = 1'b0;
        wd_stall    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (link_req && (!user_req || streak < BURST_MAX)) begin
                    state_nxt = ST_LINK;
                end else if (user_req) begin
                    state_nxt = ST_USER;
                end
            end
            ST_LINK: begin
                m_tdata     = link_tdata;
                m_tkeep     = link_tkeep;
                m_tvalid    = link_tvalid;
                m_tlast     = link_tlast;
                link_tready = m_tready;
                beat_acc    = link_tvalid && m_tready;
                wd_stall    = !link_tvalid;
                if (beat_acc && link_tlast) begin
                    state_nxt = ST_IDLE;
                end else if (wd_expire) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_USER: begin
                m_tdata     = user_tdata;
                m_tkeep     = user_tkeep;
                m_tvalid    = user_tvalid;
                m_tlast     = user_tlast;
                user_tready = m_tready;
                beat_acc    = user_tvalid && m_tready;
                wd_stall    = !user_tvalid;
                if (beat_acc && user_tlast) begin
                    state_nxt = ST_IDLE;
                end else if (wd_expire) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tuser  = 1'b1;
                m_tkeep  = ABORT_TKEEP;
                if (m_tready) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Beats of the aborted source are swallowed without reaching the MAC.
                if (flush_user) begin
                    user_tready = 1'b1;
                    beat_acc    = user_tvalid;
                    wd_stall    = !user_tvalid;
                    if (user_tvalid && user_tlast) state_nxt = ST_IDLE;
                end else begin
                    link_tready = 1'b1;
                    beat_acc    = link_tvalid;
                    wd_stall    = !link_tvalid;
                    if (link_tvalid && link_tlast) state_nxt = ST_IDLE;
                end
                if (wd_expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= ST_IDLE;
            streak         <= '0;
            flush_user     <= 1'b0;
            link_sent      <= 1'b0;
            user_sent      <= 1'b0;
            abort_pulse    <= 1'b0;
            link_frame_cnt <= '0;
            user_frame_cnt <= '0;
            abort_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            link_sent   <= (state == ST_LINK) && (state_nxt == ST_IDLE);
            user_sent   <= (state == ST_USER) && (state_nxt == ST_IDLE);
            abort_pulse <= (state != ST_ABORT) && (state_nxt == ST_ABORT);

            if ((state == ST_IDLE) && (state_nxt == ST_LINK)) begin
                if (!user_req) begin
                    streak <= '0;
                end else if (streak != 8'hFF) begin
                    streak <= streak + 8'd1;
                end
            end
            if ((state == ST_IDLE) && (state_nxt == ST_USER)) begin
                streak <= '0;
            end

            if ((state == ST_LINK) && (state_nxt == ST_IDLE)) begin
                link_frame_cnt <= link_frame_cnt + CNT_WIDTH'(1);
            end
            if ((state == ST_USER) && (state_nxt == ST_IDLE)) begin
                user_frame_cnt <= user_frame_cnt + CNT_WIDTH'(1);
            end
            if ((state != ST_ABORT) && (state_nxt == ST_ABORT)) begin
                flush_user <= (state == ST_USER);
                abort_cnt  <= abort_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_10g_ethernet_0_tcp_tx_arbiter.sv
module tb_axi_10g_ethernet_0_tcp_tx_arbiter;

    localparam int CW = 4;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          link_req = 0, user_req = 0;
    logic [63:0]   link_tdata = '0, user_tdata = '0;
    logic [7:0]    link_tkeep = '0, user_tkeep = '0;
    logic          link_tvalid = 0, link_tlast = 0, user_tvalid = 0, user_tlast = 0;
    logic          link_tready, user_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 0;
    logic          link_sent, user_sent, abort_pulse, busy;
    logic [CW-1:0] link_frame_cnt, user_frame_cnt, abort_cnt;

    always #5 aclk = ~aclk;

    axi_10g_ethernet_0_tcp_tx_arbiter #(
        .LINK_BURST_MAX(4),
        .TIMEOUT_CYCLES(1024),
        .CNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .link_req(link_req), .link_tdata(link_tdata), .link_tkeep(link_tkeep),
        .link_tvalid(link_tvalid), .link_tlast(link_tlast), .link_tready(link_tready),
        .user_req(user_req), .user_tdata(user_tdata), .user_tkeep(user_tkeep),
        .user_tvalid(user_tvalid), .user_tlast(user_tlast), .user_tready(user_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .m_tready(m_tready),
        .link_sent(link_sent), .user_sent(user_sent), .abort_pulse(abort_pulse),
        .busy(busy), .link_frame_cnt(link_frame_cnt), .user_frame_cnt(user_frame_cnt),
        .abort_cnt(abort_cnt)
    );

    int checks = 0;
    int failures = 0;
    int exp_lcnt = 0, exp_ucnt = 0, exp_acnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_cnts();
        check("link_frame_cnt", 64'(link_frame_cnt), 64'(exp_lcnt % 16));
        check("user_frame_cnt", 64'(user_frame_cnt), 64'(exp_ucnt % 16));
        check("abort_cnt",      64'(abort_cnt),      64'(exp_acnt % 16));
    endtask

    // grant: 0 none, 1 link, 2 user
    typedef struct {
        logic        lreq, ureq;
        logic [63:0] ldata, udata;
        logic [7:0]  lkeep, ukeep;
        logic        mready;
        int          grant;
        logic [63:0] exp_mdata;
        logic [7:0]  exp_mkeep;
        logic        exp_mvalid, exp_ltready, exp_utready;
    } vec_t;

    vec_t vecs[8];
    int   order[10];

    initial begin
        // Streak evolution: v1 link alone clears, v2 user clears, v3..v6 link
        // with user waiting (streak 1..4), v7 streak==4 forces user.
        vecs[0] = '{1'b0, 1'b0, 64'h1111_0000_0000_0001, 64'h2222_0000_0000_0001, 8'hFF, 8'hFF, 1'b1, 0,
                    64'h0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'hA5A5_0000_0000_0010, 64'hDEAD_BEEF_0000_0010, 8'h3F, 8'hFF, 1'b1, 1,
                    64'hA5A5_0000_0000_0010, 8'h3F, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 64'hA5A5_0000_0000_0020, 64'hDEAD_BEEF_0000_0020, 8'hFF, 8'h07, 1'b0, 2,
                    64'hDEAD_BEEF_0000_0020, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_0000_0003, 8'hFF, 8'h01, 1'b1, 1,
                    64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 64'h0000_0000_0000_0044, 64'hFFFF_0000_0000_0004, 8'h01, 8'h03, 1'b1, 1,
                    64'h0000_0000_0000_0044, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 64'h5555_5555_5555_5555, 64'hFFFF_0000_0000_0005, 8'h0F, 8'h03, 1'b1, 1,
                    64'h5555_5555_5555_5555, 8'h0F, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_0000_0006, 8'hF0, 8'h03, 1'b1, 1,
                    64'hAAAA_AAAA_AAAA_AAAA, 8'hF0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 64'h0000_0000_0000_0077, 64'hCAFE_F00D_1234_5678, 8'hFF, 8'h7F, 1'b1, 2,
                    64'hCAFE_F00D_1234_5678, 8'h7F, 1'b1, 1'b0, 1'b1};
        order = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        // ---------------- reset state ----------------
        repeat (3) @(posedge aclk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_readies", 64'({link_tready, user_tready}), 64'h0);
        areset = 1'b0;
        check_cnts();

        // ---------------- table-driven single-beat frames ----------------
        for (int i = 0; i < 8; i++) begin
            link_req = vecs[i].lreq;   user_req = vecs[i].ureq;
            link_tdata = vecs[i].ldata; user_tdata = vecs[i].udata;
            link_tkeep = vecs[i].lkeep; user_tkeep = vecs[i].ukeep;
            link_tvalid = 1; user_tvalid = 1; link_tlast = 1; user_tlast = 1;
            m_tready = vecs[i].mready;
            @(posedge aclk); #1;
            check($sformatf("v%0d_m_tdata", i), m_tdata, vecs[i].exp_mdata);
            check($sformatf("v%0d_m_tkeep", i), 64'(m_tkeep), 64'(vecs[i].exp_mkeep));
            check($sformatf("v%0d_m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].exp_mvalid));
            check($sformatf("v%0d_m_tlast", i), 64'(m_tlast), 64'(vecs[i].exp_mvalid));
            check($sformatf("v%0d_link_tready", i), 64'(link_tready), 64'(vecs[i].exp_ltready));
            check($sformatf("v%0d_user_tready", i), 64'(user_tready), 64'(vecs[i].exp_utready));
            check($sformatf("v%0d_m_tuser", i), 64'(m_tuser), 64'h0);
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].grant != 0));
            link_req = 0; user_req = 0;
            if (vecs[i].grant != 0) begin
                m_tready = 1;
                @(posedge aclk); #1;
                if (vecs[i].grant == 1) exp_lcnt++; else exp_ucnt++;
                check($sformatf("v%0d_link_sent", i), 64'(link_sent), 64'(vecs[i].grant == 1));
                check($sformatf("v%0d_user_sent", i), 64'(user_sent), 64'(vecs[i].grant == 2));
                check($sformatf("v%0d_idle_after", i), 64'(busy), 64'h0);
                check_cnts();
            end
            link_tvalid = 0; user_tvalid = 0; link_tlast = 0; user_tlast = 0;
            m_tready = 0;
        end

        // ---------------- user frame, 5 beats ----------------
        user_req = 1; user_tvalid = 1; user_tlast = 0; m_tready = 1;
        @(posedge aclk); #1;
        for (int b = 0; b < 5; b++) begin
            user_tdata = 64'h0100_0000_0000_0000 + 64'(b * 17);
            user_tkeep = (b == 4) ? 8'h0F : 8'hFF;
            user_tlast = (b == 4);
            #1;
            check($sformatf("uf_b%0d_tdata", b), m_tdata, 64'h0100_0000_0000_0000 + 64'(b * 17));
            check($sformatf("uf_b%0d_tkeep", b), 64'(m_tkeep), (b == 4) ? 64'h0F : 64'hFF);
            check($sformatf("uf_b%0d_tlast", b), 64'(m_tlast), 64'(b == 4));
            check($sformatf("uf_b%0d_sent", b), 64'(user_sent), 64'h0);
            @(posedge aclk); #1;
            user_req = 0;
        end
        exp_ucnt++;
        check("uf_user_sent", 64'(user_sent), 64'h1);
        check("uf_busy_low", 64'(busy), 64'h0);
        check_cnts();
        user_tvalid = 0; user_tlast = 0;
        @(posedge aclk); #1;
        check("uf_sent_pulse_end", 64'(user_sent), 64'h0);

        // ---------------- streak / grant order, 2-beat frames ----------------
        link_req = 1; user_req = 1; link_tvalid = 1; user_tvalid = 1;
        link_tdata = 64'h1; user_tdata = 64'h2; m_tready = 1;
        for (int f = 0; f < 10; f++) begin
            link_tlast = 0; user_tlast = 0;
            @(posedge aclk); #1;
            check($sformatf("go_f%0d_grant", f), 64'({link_tready, user_tready}),
                  (order[f] == 1) ? 64'h2 : 64'h1);
            @(posedge aclk); #1;
            link_tlast = 1; user_tlast = 1;
            @(posedge aclk); #1;
            if (order[f] == 1) exp_lcnt++; else exp_ucnt++;
            check($sformatf("go_f%0d_bubble", f), 64'(busy), 64'h0);
        end
        link_req = 0; user_req = 0; link_tvalid = 0; user_tvalid = 0;
        link_tlast = 0; user_tlast = 0;
        check_cnts();
        @(posedge aclk); #1;

        // ---------------- MAC backpressure, no abort ----------------
        begin
            int ab;
            ab = 0;
            link_req = 1; link_tvalid = 1; link_tlast = 0; link_tdata = 64'hB0B0; m_tready = 1;
            @(posedge aclk); #1;
            @(posedge aclk); #1;
            link_req = 0; m_tready = 0; link_tdata = 64'hB1B1;
            for (int c = 0; c < 2000; c++) begin
                @(posedge aclk); #1;
                if (abort_pulse || m_tuser || !busy) ab++;
            end
            check("bp_no_abort", 64'(ab), 64'h0);
            check("bp_m_tvalid", 64'(m_tvalid), 64'h1);
            check("bp_m_tdata", m_tdata, 64'hB1B1);
            m_tready = 1; link_tlast = 1;
            @(posedge aclk); #1;
            exp_lcnt++;
            check("bp_link_sent", 64'(link_sent), 64'h1);
            check_cnts();
            link_tvalid = 0; link_tlast = 0;
        end

        // ---------------- user stall -> abort -> flush ----------------
        user_req = 1; user_tvalid = 1; user_tlast = 0; m_tready = 1;
        @(posedge aclk); #1;
        user_tdata = 64'hC0; @(posedge aclk); #1;
        user_req = 0;
        user_tdata = 64'hC1; @(posedge aclk); #1;
        user_tvalid = 0; m_tready = 0;
        repeat (1023) @(posedge aclk);
        #1;
        check("ab_not_yet_tuser", 64'(m_tuser), 64'h0);
        check("ab_not_yet_pulse", 64'(abort_pulse), 64'h0);
        @(posedge aclk); #1;
        exp_acnt++;
        check("ab_pulse", 64'(abort_pulse), 64'h1);
        check("ab_m_tuser", 64'(m_tuser), 64'h1);
        check("ab_m_tlast", 64'(m_tlast), 64'h1);
        check("ab_m_tvalid", 64'(m_tvalid), 64'h1);
        check("ab_m_tkeep", 64'(m_tkeep), 64'h01);
        check("ab_m_tdata", m_tdata, 64'h0);
        check("ab_readies", 64'({link_tready, user_tready}), 64'h0);
        check_cnts();
        @(posedge aclk); #1;
        check("ab_hold_tvalid", 64'(m_tvalid), 64'h1);
        check("ab_pulse_once", 64'(abort_pulse), 64'h0);
        m_tready = 1;
        @(posedge aclk); #1;
        user_tvalid = 1;
        for (int b = 0; b < 3; b++) begin
            user_tdata = 64'hD0 + 64'(b);
            user_tlast = (b == 2);
            #1;
            check($sformatf("fl_b%0d_tready", b), 64'(user_tready), 64'h1);
            check($sformatf("fl_b%0d_m_tvalid", b), 64'(m_tvalid), 64'h0);
            @(posedge aclk); #1;
        end
        user_tvalid = 0; user_tlast = 0;
        check("fl_idle", 64'(busy), 64'h0);
        check("fl_no_sent", 64'(user_sent), 64'h0);
        check_cnts();

        // ---------------- async reset mid-frame ----------------
        link_req = 1; link_tvalid = 1; link_tlast = 0; m_tready = 1;
        @(posedge aclk); #1;
        link_tdata = 64'hE0; @(posedge aclk); #1;
        link_tdata = 64'hE1; @(posedge aclk); #1;
        link_tdata = 64'hE2;
        #2;
        check("pre_rst_m_tvalid", 64'(m_tvalid), 64'h1);
        areset = 1;
        #1;
        exp_lcnt = 0; exp_ucnt = 0; exp_acnt = 0;
        check("ar_m_tvalid", 64'(m_tvalid), 64'h0);
        check("ar_m_tdata", m_tdata, 64'h0);
        check("ar_link_tready", 64'(link_tready), 64'h0);
        check("ar_busy", 64'(busy), 64'h0);
        check_cnts();
        @(posedge aclk); #1;
        areset = 0;
        link_tdata = 64'hF00D; link_tlast = 1;
        @(posedge aclk); #1;
        link_req = 0;
        check("ar_regrant_tready", 64'(link_tready), 64'h1);
        check("ar_regrant_tdata", m_tdata, 64'hF00D);
        @(posedge aclk); #1;
        exp_lcnt++;
        check("ar_regrant_sent", 64'(link_sent), 64'h1);
        check_cnts();
        link_tvalid = 0; link_tlast = 0;

        // ---------------- counter wrap: 17 link frames, CNT_WIDTH=4 ----------------
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        link_tvalid = 1; link_tlast = 1; m_tready = 1;
        for (int f = 0; f < 17; f++) begin
            link_req = 1;
            @(posedge aclk); #1;
            link_req = 0;
            @(posedge aclk); #1;
        end
        check("wrap_link_cnt", 64'(link_frame_cnt), 64'h1);
        link_tvalid = 0; link_tlast = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
